// File: rtl/gray_checker.sv
// rtl/gray_checker.sv - Gray-code stream decoder and single-step link monitor
module gray_checker #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] gray_in_i,
    output logic [WIDTH-1:0] binary_o,
    output logic             bin_valid_o,
    output logic             wrap_o,
    output logic [7:0]       wrap_count_o,
    output logic             error_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] binary_q;
    logic             bin_valid_q;
    logic             wrap_q;
    logic [7:0]       wrap_count_q;
    logic             error_q;

    logic [WIDTH-1:0] gray_dec;
    logic [WIDTH-1:0] succ;
    logic             at_top;

    // Binary bit i is the XOR of all Gray bits at or above position i.
    always_comb begin
        gray_dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            gray_dec[i] = ^(gray_in_i >> i);
        end
    end

    assign succ   = binary_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign at_top = (binary_q == {WIDTH{1'b1}});

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            binary_q     <= '0;
            bin_valid_q  <= 1'b0;
            wrap_q       <= 1'b0;
            wrap_count_q <= 8'd0;
            error_q      <= 1'b0;
        end else begin
            bin_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            if (in_valid_i) begin
                case (state_q)
                    ST_IDLE: begin
                        binary_q    <= gray_dec;
                        bin_valid_q <= 1'b1;
                        state_q     <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (gray_dec == binary_q) begin
                            bin_valid_q <= 1'b1;
                        end else if (gray_dec == succ) begin
                            binary_q    <= gray_dec;
                            bin_valid_q <= 1'b1;
                            if (at_top) begin
                                wrap_q <= 1'b1;
                                if (wrap_count_q != 8'hFF) begin
                                    wrap_count_q <= wrap_count_q + 8'd1;
                                end
                            end
                        end else begin
                            error_q <= 1'b1;
                            state_q <= ST_FAULT;
                        end
                    end
                    ST_FAULT: begin
                        // Only an all-zero code re-establishes the reference.
                        if (gray_in_i == '0) begin
                            binary_q    <= '0;
                            bin_valid_q <= 1'b1;
                            state_q     <= ST_TRACK;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign binary_o     = binary_q;
    assign bin_valid_o  = bin_valid_q;
    assign wrap_o       = wrap_q;
    assign wrap_count_o = wrap_count_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_gray_checker.sv
// tb/tb_gray_checker.sv - randomized and directed bench for gray_checker
module tb_gray_checker;

    localparam int W = 3;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         reset_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic [W-1:0] gray_in_i = '0;
    logic [W-1:0] binary_o;
    logic         bin_valid_o;
    logic         wrap_o;
    logic [7:0]   wrap_count_o;
    logic         error_o;

    always #5 clk = ~clk;

    gray_checker #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .in_valid_i   (in_valid_i),
        .gray_in_i    (gray_in_i),
        .binary_o     (binary_o),
        .bin_valid_o  (bin_valid_o),
        .wrap_o       (wrap_o),
        .wrap_count_o (wrap_count_o),
        .error_o      (error_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: 0 = no reference, 1 = tracking, 2 = faulted.
    int m_mode = 0;
    int m_p    = 0;
    int m_cnt  = 0;
    int m_err  = 0;
    int m_bv   = 0;
    int m_wrap = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gray(input int n);
        return n ^ (n >> 1);
    endfunction

    function automatic int ungray(input int g);
        for (int n = 0; n < N; n++) begin
            if (gray(n) == g) return n;
        end
        return -1;
    endfunction

    task automatic model(input bit r, input bit v, input int g);
        int d;
        m_bv   = 0;
        m_wrap = 0;
        if (r) begin
            m_mode = 0; m_p = 0; m_cnt = 0; m_err = 0;
        end else if (v) begin
            d = ungray(g);
            if (m_mode == 0) begin
                m_p = d; m_bv = 1; m_mode = 1;
            end else if (m_mode == 1) begin
                if (d == m_p) begin
                    m_bv = 1;
                end else if (d == (m_p + 1) % N) begin
                    if (m_p == N - 1) begin
                        m_wrap = 1;
                        if (m_cnt < 255) m_cnt++;
                    end
                    m_p = d; m_bv = 1;
                end else begin
                    m_err = 1; m_mode = 2;
                end
            end else if (g == 0) begin
                m_p = 0; m_bv = 1; m_mode = 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input int g);
        logic [31:0] gv;
        gv = g;
        @(negedge clk);
        reset_i    = r;
        in_valid_i = v;
        gray_in_i  = gv[W-1:0];
        @(posedge clk);
        #1;
        model(r, v, g);
        check_eq("binary",     binary_o,     m_p);
        check_eq("bin_valid",  bin_valid_o,  m_bv);
        check_eq("wrap",       wrap_o,       m_wrap);
        check_eq("wrap_count", wrap_count_o, m_cnt);
        check_eq("error",      error_o,      m_err);
    endtask

    task automatic send_bin(input int b);
        step(1'b0, 1'b1, gray(b));
    endtask

    initial begin
        int r;
        int g;

        // Full cycle with one wrap
        step(1'b1, 1'b0, 0);
        check_eq("reset_binary", binary_o, 0);
        check_eq("reset_error", error_o, 0);
        for (int i = 0; i <= N; i++) send_bin(i % N);
        check_eq("cycle_wrapcnt", wrap_count_o, 1);

        // Hold and gaps
        step(1'b1, 1'b0, 0);
        send_bin(0); send_bin(1); send_bin(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
        send_bin(2);
        check_eq("gap_binary", binary_o, 2);

        // Skip fault, ignored sample, resync, reset clears error
        step(1'b1, 1'b0, 0);
        send_bin(0); send_bin(1);
        step(1'b0, 1'b1, 3'b010);
        check_eq("skip_error", error_o, 1);
        step(1'b0, 1'b1, 3'b110);
        check_eq("fault_hold", binary_o, 1);
        step(1'b0, 1'b1, 3'b000);
        step(1'b0, 1'b1, 3'b001);
        check_eq("resync_error", error_o, 1);
        step(1'b1, 1'b0, 0);
        check_eq("reset_clears_error", error_o, 0);

        // Fresh reference and reset priority over a sample
        step(1'b0, 1'b1, 3'b110);
        check_eq("idle_ref", binary_o, 4);
        step(1'b0, 1'b1, 3'b111);
        step(1'b1, 1'b1, 3'b101);
        check_eq("reset_prio_bv", bin_valid_o, 0);
        step(1'b0, 1'b1, 3'b010);
        check_eq("new_ref", binary_o, 3);

        // Resync from top value does not count as wrap
        step(1'b1, 1'b0, 0);
        send_bin(N - 1);
        send_bin(2);
        step(1'b0, 1'b1, 0);
        check_eq("resync_no_wrap", wrap_o, 0);

        // Saturation
        step(1'b1, 1'b0, 0);
        send_bin(0);
        for (int c = 0; c < 260; c++) begin
            for (int i = 1; i <= N; i++) send_bin(i % N);
        end
        check_eq("sat_count", wrap_count_o, 255);

        // Randomized mix
        step(1'b1, 1'b0, 0);
        for (int k = 0; k < 2000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      g = gray((m_p + 1) % N);
            else if (r < 60) g = gray(m_p);
            else if (r < 75) g = 0;
            else             g = $urandom_range(0, N - 1);
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 75), g);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gray_checker.md
# gray_checker

Receiving end of the Gray-code counter stream used in this design. It samples a WIDTH-bit Gray code on a valid strobe and decodes it to binary. It verifies that each sample is either a repeat or the exact single-step successor of the last accepted value, and reports wrap-arounds and protocol faults. It sits downstream of the Gray counter as a decoder and link monitor.

## Interface
- WIDTH, 3: Gray/binary code width, ≥2.
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high; dominates all other inputs.
- In_valid  input  1  Gray_in is sampled this cycle when 1.
- Gray_in  input  WIDTH  Gray-coded sample.
- Binary  output  WIDTH  decoded value of the last accepted sample (registered).
- Bin_valid  output  1  one-cycle pulse; Binary updated from an accepted sample.
- Wrap  output  1  one-cycle pulse; accepted step from 2^WIDTH−1 to 0.
- Wrap_count  output  8  number of wraps since reset, saturates at 255.
- Error  output  1  sticky fault flag, cleared only by Reset.

## Operation
- Decode: b[WIDTH−1]=g[WIDTH−1]; b[i]=b[i+1]^g[i] for i<WIDTH−1. Call the result d and the last accepted binary value p. succ(p)=(p+1) mod 2^WIDTH.
- States: IDLE (no reference yet), TRACK, FAULT.
- IDLE, In_valid=1: accept any d. Binary<=d, Bin_valid pulse, go to TRACK. No Wrap.
- TRACK, In_valid=1:
  - d==p: hold. Bin_valid pulses and Binary is unchanged.
  - d==succ(p): Binary<=d, Bin_valid pulse. If p==2^WIDTH−1, Wrap pulses and Wrap_count increments (holds at 255).
  - otherwise: Error<=1, go to FAULT. Binary holds, no Bin_valid, no Wrap.
- FAULT, In_valid=1: if Gray_in==0, resync: Binary<=0, Bin_valid pulse, go to TRACK, no Wrap, Error stays 1. Any other value is ignored.
- In_valid=0 in any state: no state change, pulses deassert.
- Reset values: state IDLE, Binary=0, Bin_valid=0, Wrap=0, Wrap_count=0, Error=0.

## Timing
- All outputs are registered. A sample on edge k appears on Binary, Bin_valid, Wrap, Wrap_count and Error after edge k.
- Latency is 1 cycle. The block accepts one sample per cycle with back-to-back In_valid and has no stall.
- Bin_valid and Wrap are high for exactly one cycle per qualifying sample.
- Reset asserted together with In_valid: the reset applies and the sample is discarded. Reset mid-stream returns to IDLE, so the next sample is taken as a fresh reference.
- Wrap_count at 255 with another wrap: Wrap still pulses and the count stays 255.
- FAULT resync with 0 is not counted as a wrap, even if the last good p was 2^WIDTH−1.

## Test plan
- Full cycle, WIDTH=3: Reset, then In_valid each cycle with 000,001,011,010,110,111,101,100,000 -> Binary 0,1,2,3,4,5,6,7,0, each one cycle later with Bin_valid=1. Wrap pulses only on the final sample, Wrap_count=1, Error=0.
- Hold and gaps: 000,001,001, then In_valid=0 for 3 cycles, then 011 -> Binary 0,1,1,2. Bin_valid pulses 4 times and is 0 during the gap. Error=0.
- Skip fault: 000,001,010 (binary 3 after 1) -> Error=1 from the cycle after 010, Binary stays 1, no Bin_valid for 010. A later 110 is ignored and Binary stays 1.
- Resync: from FAULT apply 000 then 001 -> Binary 0 then 1 with Bin_valid pulses, Wrap=0, Error remains 1. Reset -> Error=0, Wrap_count=0, state IDLE.
- IDLE reference and reset priority: after Reset the first sample is 110 -> Binary=4. Next is 111 -> Binary=5. Then Reset=1 with In_valid=1 and Gray_in=101 -> Binary=0, no Bin_valid. Next sample 010 -> Binary=3 accepted as the new reference.
- Saturation: drive 260 full Gray cycles -> Wrap pulses 260 times, Wrap_count climbs and holds at 255, Error=0.
